// File: rtl/vec_deser_pkg.sv
// Shared types and constants for the bit-serial vector deserializer.
package vec_deser_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Serial bits per frame: the data word plus an optional trailing parity bit.
  function automatic int frame_len(input int width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction

endpackage

// File: rtl/vector_deserializer_bit_order_mux.sv
// Combinational bit-order selector: passes the word through or bit-reverses it.
module bit_order_mux #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in,
  input  logic             rev,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = in;
    if (rev) begin
      for (int i = 0; i < WIDTH; i++) begin
        out[i] = in[WIDTH-1-i];
      end
    end
  end

endmodule

// File: rtl/vector_deserializer.sv
// Bit-serial to parallel collector with a valid/ready output holding register.
// Optional even-parity frame checking is enabled by defining VEC_DESER_PARITY_EN.
module vector_deserializer
  import vec_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  input  logic                       msb_first,
  input  logic                       clear,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overrun,
  output logic                       parity_err,
  output logic [$clog2(WIDTH+1)-1:0] bit_count
);

`ifdef VEC_DESER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
  localparam int SW        = WIDTH;
`else
  localparam bit PARITY_EN = 1'b0;
  // The final data bit is taken straight from bit_in, so only WIDTH-1 bits are stored.
  localparam int SW        = WIDTH - 1;
`endif

  localparam int             FRAME = frame_len(WIDTH, PARITY_EN);
  localparam int             CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST  = CW'(FRAME - 1);

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   shift_q;
  logic            order_q;
  logic [WIDTH-1:0] assembled;
  logic [WIDTH-1:0] ordered;
  logic            shift_en;
  logic            last_bit;
  logic            complete;
  logic            frame_ok;
  logic            slot_free;
  logic            load;

  assign last_bit  = (state == COLLECT) && bit_valid && (cnt == LAST);
  assign complete  = last_bit && !clear;
  assign slot_free = !out_valid || out_ready;
  assign load      = complete && frame_ok && slot_free;
  assign bit_count = cnt;

`ifdef VEC_DESER_PARITY_EN
  localparam logic [CW-1:0] DATA_END = CW'(WIDTH);

  // The parity bit is checked against the stored data but never shifted in.
  assign shift_en  = (cnt < DATA_END);
  assign assembled = shift_q;
  assign frame_ok  = ~((^shift_q) ^ bit_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= complete && !frame_ok;
    end
  end
`else
  assign shift_en   = 1'b1;
  assign assembled  = {bit_in, shift_q};
  assign frame_ok   = 1'b1;
  assign parity_err = 1'b0;
`endif

  bit_order_mux #(.WIDTH(WIDTH)) u_order_mux (
    .in  (assembled),
    .rev (order_q),
    .out (ordered)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (bit_valid) next_state = COLLECT;
        COLLECT: if (last_bit) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Incoming bits enter at the top and move down, so the first bit ends in bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      shift_q <= '0;
      order_q <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
    end else if (bit_valid) begin
      cnt <= last_bit ? '0 : cnt + 1'b1;
      if (shift_en) begin
        shift_q <= (shift_q >> 1) | (SW'(bit_in) << (SW - 1));
      end
      if (state == IDLE) begin
        order_q <= msb_first;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (clear) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        out_data  <= ordered;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (complete && frame_ok && !slot_free) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
